lcd_frame_scheduler: RTL and testbench
======================================

# lcd_frame_scheduler

Sequencer and arbiter for the shared LCD byte-write channel (`lcd_write`). It sits between `lcd_init`, a pixel source and an auxiliary command requester, and owns the single `{dc,byte}` write port. Until `init_done` it passes the initialisation stream through unchanged. After that it issues the full-screen window commands (CASET/RASET/RAMWR) each frame, streams RGB565 pixels as two bytes each, and inserts auxiliary command bursts only between frames.

## Interface
- `H_RES`, 240, active columns.
- `V_RES`, 320, active rows.
- `X_OFS`, 0, column offset of the window start.
- `Y_OFS`, 0, row offset of the window start.

Ports:
- `clk_50MHz`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `init_done`  in  1  level from `lcd_init`.
- `init_data`  in  9  byte word from `lcd_init`.
- `init_en`  in  1  write enable from `lcd_init`.
- `wr_done`  in  1  one-cycle pulse from `lcd_write` when the current byte completes.
- `lcd_data`  out  9  word to `lcd_write`. Bit 8 is dc: 0 = command, 1 = data.
- `lcd_en`  out  1  write request to `lcd_write`.
- `frame_en`  in  1  permits new frames to start.
- `pix_data`  in  16  RGB565 pixel.
- `pix_valid`  in  1  pixel available.
- `pix_ready`  out  1  scheduler takes the pixel this cycle.
- `cmd_req`  in  1  auxiliary word available.
- `cmd_word`  in  9  auxiliary `{dc,byte}`.
- `cmd_last`  in  1  this word ends the burst.
- `cmd_ack`  out  1  one-cycle pulse: `cmd_word`/`cmd_last` captured.
- `frame_start`  out  1  pulse on the first window byte of a frame.
- `frame_done`  out  1  pulse after the last pixel byte completes.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** WAIT_INIT, IDLE, AUX_LOAD, AUX_SEND, WIN, FETCH, PIX_HI, PIX_LO.
- **Reset:** state WAIT_INIT; counters cleared. `pix_ready`, `cmd_ack`, `frame_start` and `frame_done` = 0. `busy` = 1.
- **WAIT_INIT:**
  - `lcd_data`/`lcd_en` are a combinational mux of `init_data`/`init_en`.
  - When `init_done` = 1, go to IDLE next cycle. The block never returns to WAIT_INIT except on `rst`.
  - Outside WAIT_INIT, `lcd_data`/`lcd_en` are registered and `lcd_data` holds 9'h000 when idle.
- **IDLE:**
  - `cmd_req` has priority: go to AUX_LOAD.
  - Otherwise, if `frame_en`, go to WIN.
  - Otherwise, stay in IDLE.
- **AUX_LOAD:**
  - Waits for `cmd_req`. On `cmd_req` = 1, capture `cmd_word`/`cmd_last`, pulse `cmd_ack` the same cycle, and go to AUX_SEND.
  - A burst is never interrupted. After a non-last word, the block waits in AUX_LOAD indefinitely.
- **AUX_SEND:** drives the captured word. On `wr_done`: if last, go to IDLE; otherwise go to AUX_LOAD.
- **WIN:** sends 11 words from a 4-bit index, with XE = X_OFS+H_RES-1 and YE = Y_OFS+V_RES-1, all 16-bit, big-endian:
  - 9'h02A
  - X_OFS[15:8], X_OFS[7:0], XE[15:8], XE[7:0] (each with dc = 1)
  - 9'h02B
  - Y_OFS and YE in the same form
  - 9'h02C
  - After the 9'h02C `wr_done`, go to FETCH.
- **FETCH:**
  - `pix_ready` = 1 and `lcd_en` = 0.
  - On `pix_valid` (transfer = `pix_valid` & `pix_ready`), latch `pix_data` and go to PIX_HI.
  - Stalls of any length are permitted.
- **PIX_HI:** drives {1, px[15:8]}. On `wr_done`, go to PIX_LO.
- **PIX_LO:** drives {1, px[7:0]}. On `wr_done`:
  - If pixel count = H_RES*V_RES−1: pulse `frame_done`, clear the count, go to IDLE.
  - Otherwise: increment the count, go to FETCH.
- **Pixel counter:** width `$clog2(H_RES*V_RES)`, compared against the exact last index; it never wraps inside a frame.
- **`frame_en` deasserted mid-frame:** no effect; the frame completes.
- **`cmd_req` during a frame:** ignored until IDLE; `cmd_ack` stays 0.
- **`wr_done` while `lcd_en` = 0:** ignored.
- **`rst` mid-frame or mid-burst:** return to WAIT_INIT. `lcd_en` follows `init_en` in the next cycle. No `frame_done` and no `cmd_ack` are issued.

## Timing
- **Byte handshake:**
  - `lcd_en` rises with the word already stable and holds both until the `wr_done` cycle.
  - The edge after `wr_done` drops `lcd_en` for exactly one cycle (FETCH may extend this).
  - The next word is presented with `lcd_en` = 1 on the following edge.
  - Every byte is therefore preceded by at least one low cycle of `lcd_en`.
- **`init_done` sampled high:** IDLE next cycle. If `frame_en`, WIN follows, with `lcd_en` = 1, `lcd_data` = 9'h02A and a `frame_start` pulse registered together on the next edge.
- **FETCH latency:** the transfer cycle → `lcd_en` = 1 on the next edge.
- **`frame_done`:** asserted the cycle after the final `wr_done` (the IDLE entry cycle).
- **`cmd_ack`:** combinational with the capture cycle; AUX_SEND drives the word from the next edge.

## Test plan
- **Init pass-through:** `init_en`/`init_data` toggled while `init_done` = 0 → `lcd_en`/`lcd_data` mirror them in the same cycle. Raise `init_done` → `busy` = 0 one cycle later.
- **Default window, `frame_en` = 1:** words captured on each `wr_done` = 02A, 100, 100, 100, 1EF, 02B, 100, 100, 101, 13F, 02C; `frame_start` is one pulse, on the first word.
- **Pixel stream:** H_RES = 2, V_RES = 2, pixels 0xF800, 0x07E0, 0x001F, 0xFFFF with 0–5-cycle `pix_valid` gaps → bytes 1F8, 100, 107, 1E0, 100, 11F, 1FF, 1FF. Exactly four `pix_ready` transfers; `frame_done` one cycle after the 8th `wr_done`.
- **Aux arbitration:** `cmd_req` asserted mid-frame with burst 036/160 (`cmd_last` on the 2nd word) → no `cmd_ack` until `frame_done`. Then both words are sent before the next 9'h02A.
- **Reset mid-PIX_HI:** `rst` for 1 cycle with `lcd_en` = 1 → next cycle `lcd_en` = `init_en`, `busy` = 1, `pix_ready` = 0. The next frame after `init_done` restarts at 9'h02A with pixel count 0.
- **`frame_en` = 0 in IDLE:** `lcd_en` stays 0 and `busy` stays 0 for ≥100 cycles; a `cmd_req` burst is still served.

Source files
------------

// File: rtl/lcd_frame_scheduler_if.sv
// Purpose: bundles the scheduler's init, byte-writer, pixel and aux-command signals.
// Latency: none; this is wiring only.
// Backpressure: pixel uses pix_valid/pix_ready, aux uses cmd_req/cmd_ack, the byte port uses lcd_en/wr_done.
// Ports: master = scheduler side (drives lcd_*, pix_ready, cmd_ack, frame_*, busy);
//        slave  = environment side (lcd_init, lcd_write, pixel source, command requester).
interface lcd_frame_scheduler_if;
    logic        init_done;
    logic [8:0]  init_data;
    logic        init_en;
    logic        wr_done;
    logic [8:0]  lcd_data;
    logic        lcd_en;
    logic        frame_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        cmd_req;
    logic [8:0]  cmd_word;
    logic        cmd_last;
    logic        cmd_ack;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    modport master (
        input  init_done, init_data, init_en, wr_done,
        input  frame_en, pix_data, pix_valid,
        input  cmd_req, cmd_word, cmd_last,
        output lcd_data, lcd_en, pix_ready, cmd_ack,
        output frame_start, frame_done, busy
    );

    modport slave (
        output init_done, init_data, init_en, wr_done,
        output frame_en, pix_data, pix_valid,
        output cmd_req, cmd_word, cmd_last,
        input  lcd_data, lcd_en, pix_ready, cmd_ack,
        input  frame_start, frame_done, busy
    );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// Purpose: owns the LCD {dc,byte} write port; passes init through, then sends window cmds + RGB565 frames, aux bursts between frames.
// Latency: pixel transfer -> lcd_en on next edge; every byte is preceded by at least one low cycle of lcd_en.
// Backpressure: holds each byte until wr_done; pix_ready only in FETCH; cmd_ack only while waiting for an aux word.
// Ports: clk_50MHz/rst (sync, active-high); bus = master modport of lcd_frame_scheduler_if.
module lcd_frame_scheduler #(
    parameter int H_RES = 240,
    parameter int V_RES = 320,
    parameter int X_OFS = 0,
    parameter int Y_OFS = 0
) (
    input  logic                  clk_50MHz,
    input  logic                  rst,
    lcd_frame_scheduler_if.master bus
);
    localparam int                PIX_N    = H_RES * V_RES;
    localparam int                CNT_W    = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam logic [CNT_W-1:0]  PIX_LAST = CNT_W'(PIX_N - 1);
    localparam logic [15:0]       XS       = 16'(X_OFS);
    localparam logic [15:0]       XE       = 16'(X_OFS + H_RES - 1);
    localparam logic [15:0]       YS       = 16'(Y_OFS);
    localparam logic [15:0]       YE       = 16'(Y_OFS + V_RES - 1);

    typedef enum logic [2:0] {
        WAIT_INIT, IDLE, AUX_LOAD, AUX_SEND, WIN, FETCH, PIX_HI, PIX_LO
    } state_t;

    state_t           state;
    logic [3:0]       win_idx;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       px_lo;
    logic             aux_last;
    logic [8:0]       data_r;
    logic             en_r;
    logic             frame_start_r;
    logic             frame_done_r;
    logic [8:0]       win_word;
    logic             wr_ack;

    // wr_done only counts against a byte we are actually presenting.
    assign wr_ack = en_r & bus.wr_done;

    always_comb begin
        win_word = 9'h000;
        case (win_idx)
            4'd0:    win_word = 9'h02A;
            4'd1:    win_word = {1'b1, XS[15:8]};
            4'd2:    win_word = {1'b1, XS[7:0]};
            4'd3:    win_word = {1'b1, XE[15:8]};
            4'd4:    win_word = {1'b1, XE[7:0]};
            4'd5:    win_word = 9'h02B;
            4'd6:    win_word = {1'b1, YS[15:8]};
            4'd7:    win_word = {1'b1, YS[7:0]};
            4'd8:    win_word = {1'b1, YE[15:8]};
            4'd9:    win_word = {1'b1, YE[7:0]};
            4'd10:   win_word = 9'h02C;
            default: win_word = 9'h000;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state         <= WAIT_INIT;
            win_idx       <= '0;
            pix_cnt       <= '0;
            px_lo         <= '0;
            aux_last      <= 1'b0;
            data_r        <= '0;
            en_r          <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            case (state)
                WAIT_INIT: begin
                    if (bus.init_done) state <= IDLE;
                end
                IDLE: begin
                    if (bus.cmd_req) begin
                        state <= AUX_LOAD;
                    end else if (bus.frame_en) begin
                        // First window word goes out together with frame_start.
                        state         <= WIN;
                        win_idx       <= 4'd0;
                        data_r        <= 9'h02A;
                        en_r          <= 1'b1;
                        frame_start_r <= 1'b1;
                    end
                end
                AUX_LOAD: begin
                    if (bus.cmd_req) begin
                        data_r   <= bus.cmd_word;
                        aux_last <= bus.cmd_last;
                        en_r     <= 1'b1;
                        state    <= AUX_SEND;
                    end
                end
                AUX_SEND: begin
                    if (wr_ack) begin
                        en_r <= 1'b0;
                        if (aux_last) begin
                            data_r <= '0;
                            state  <= IDLE;
                        end else begin
                            state <= AUX_LOAD;
                        end
                    end
                end
                WIN: begin
                    if (wr_ack) begin
                        en_r <= 1'b0;
                        if (win_idx == 4'd10) state <= FETCH;
                        else                  win_idx <= win_idx + 4'd1;
                    end else if (!en_r) begin
                        // One low cycle after each byte, then the next index.
                        en_r   <= 1'b1;
                        data_r <= win_word;
                    end
                end
                FETCH: begin
                    if (bus.pix_valid) begin
                        px_lo  <= bus.pix_data[7:0];
                        data_r <= {1'b1, bus.pix_data[15:8]};
                        en_r   <= 1'b1;
                        state  <= PIX_HI;
                    end
                end
                PIX_HI: begin
                    if (wr_ack) begin
                        en_r  <= 1'b0;
                        state <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (wr_ack) begin
                        en_r <= 1'b0;
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt      <= '0;
                            frame_done_r <= 1'b1;
                            data_r       <= '0;
                            state        <= IDLE;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                            state   <= FETCH;
                        end
                    end else if (!en_r) begin
                        en_r   <= 1'b1;
                        data_r <= {1'b1, px_lo};
                    end
                end
                default: state <= WAIT_INIT;
            endcase
        end
    end

    // Before init completes the init stream owns the port combinationally.
    assign bus.lcd_en      = (state == WAIT_INIT) ? bus.init_en   : en_r;
    assign bus.lcd_data    = (state == WAIT_INIT) ? bus.init_data : data_r;
    assign bus.pix_ready   = (state == FETCH);
    assign bus.cmd_ack     = (state == AUX_LOAD) && bus.cmd_req;
    assign bus.busy        = (state != IDLE);
    assign bus.frame_start = frame_start_r;
    assign bus.frame_done  = frame_done_r;
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
`timescale 1ns/1ps
module tb_lcd_frame_scheduler;
    logic clk_50MHz = 1'b0;
    logic rst_a;
    logic rst_b;
    always #10 clk_50MHz = ~clk_50MHz;

    lcd_frame_scheduler_if bus_a ();
    lcd_frame_scheduler_if bus_b ();

    // Default geometry: used for the full-screen window words only.
    lcd_frame_scheduler u_dut_a (.clk_50MHz(clk_50MHz), .rst(rst_a), .bus(bus_a));
    // 2x2 geometry: pixel stream, arbitration and reset scenarios.
    lcd_frame_scheduler #(.H_RES(2), .V_RES(2)) u_dut_b (.clk_50MHz(clk_50MHz), .rst(rst_b), .bus(bus_b));

    localparam int LIMIT = 500;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    int fs_cnt_a = 0;
    int fs_cnt_b = 0;
    int fd_cnt_b = 0;
    int xfer_b   = 0;
    int ack_b    = 0;
    int bytes_b  = 0;
    bit in_frame_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_b(input logic [8:0] w);
        exp_b.push_back(w);
    endtask

    task automatic push_win_2x2();
        logic [8:0] w[11];
        w = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
        foreach (w[i]) exp_b.push_back(w[i]);
    endtask

    // Scoreboard + lcd_write model for DUT B: samples 2 ns after the falling edge.
    initial begin : mon_b
        int hc;
        logic [8:0] e;
        hc = 0;
        bus_b.wr_done = 1'b0;
        forever begin
            @(negedge clk_50MHz);
            #2;
            if (rst_b) begin
                in_frame_b    = 1'b0;
                bytes_b       = 0;
                hc            = 0;
                bus_b.wr_done = 1'b0;
            end else begin
                if (bus_b.frame_start) begin
                    fs_cnt_b++;
                    check("b_frame_start_word", {23'd0, bus_b.lcd_en, bus_b.lcd_data}, {23'd0, 1'b1, 9'h02A});
                    in_frame_b = 1'b1;
                    bytes_b    = 0;
                end
                if (bus_b.frame_done) begin
                    fd_cnt_b++;
                    // The final wr_done was taken on the edge just passed.
                    check("b_frame_done_timing", {31'd0, bus_b.wr_done}, 32'd1);
                    check("b_frame_bytes", bytes_b, 32'd19);
                    in_frame_b = 1'b0;
                end
                if (bus_b.cmd_ack) begin
                    ack_b++;
                    check("b_ack_outside_frame", {31'd0, in_frame_b}, 32'd0);
                end
                if (bus_b.pix_valid && bus_b.pix_ready) xfer_b++;
                if (bus_b.wr_done) begin
                    bus_b.wr_done = 1'b0;
                    hc = 0;
                end else if (bus_b.lcd_en) begin
                    hc++;
                    if (hc >= 2) begin
                        if (exp_b.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL b_write: unexpected word 0x%0h, expected none", bus_b.lcd_data);
                        end else begin
                            e = exp_b.pop_front();
                            check("b_write_word", {23'd0, bus_b.lcd_data}, {23'd0, e});
                        end
                        bytes_b++;
                        bus_b.wr_done = 1'b1;
                    end
                end else begin
                    hc = 0;
                end
            end
        end
    end

    // Scoreboard + lcd_write model for DUT A (slower writer).
    initial begin : mon_a
        int hc;
        logic [8:0] e;
        hc = 0;
        bus_a.wr_done = 1'b0;
        forever begin
            @(negedge clk_50MHz);
            #2;
            if (bus_a.frame_start) begin
                fs_cnt_a++;
                check("a_frame_start_word", {23'd0, bus_a.lcd_data}, {23'd0, 9'h02A});
            end
            if (bus_a.wr_done) begin
                bus_a.wr_done = 1'b0;
                hc = 0;
            end else if (bus_a.lcd_en && !rst_a) begin
                hc++;
                if (hc >= 3) begin
                    if (exp_a.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL a_write: unexpected word 0x%0h, expected none", bus_a.lcd_data);
                    end else begin
                        e = exp_a.pop_front();
                        check("a_window_word", {23'd0, bus_a.lcd_data}, {23'd0, e});
                    end
                    bus_a.wr_done = 1'b1;
                end
            end else begin
                hc = 0;
            end
        end
    end

    // DUT A stimulus: init already done, frames enabled, no pixels ever offered.
    initial begin : stim_a
        logic [8:0] w[11];
        w = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
              9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
        foreach (w[i]) exp_a.push_back(w[i]);
        rst_a = 1'b1;
        bus_a.init_done = 1'b1;
        bus_a.init_data = 9'h000;
        bus_a.init_en   = 1'b0;
        bus_a.frame_en  = 1'b1;
        bus_a.pix_data  = 16'h0000;
        bus_a.pix_valid = 1'b0;
        bus_a.cmd_req   = 1'b0;
        bus_a.cmd_word  = 9'h000;
        bus_a.cmd_last  = 1'b0;
        repeat (2) @(negedge clk_50MHz);
        rst_a = 1'b0;
    end

    // Drivers are entered on a falling edge; they change inputs there and read DUT outputs 1 ns later.
    task automatic drive_pixel(input logic [15:0] p, input int gap);
        int n;
        repeat (gap) @(negedge clk_50MHz);
        bus_b.pix_data  = p;
        bus_b.pix_valid = 1'b1;
        n = 0;
        #1;
        while (!bus_b.pix_ready && n < LIMIT) begin
            @(negedge clk_50MHz);
            #1;
            n++;
        end
        check("pix_ready_timeout", {31'd0, n >= LIMIT}, 32'd0);
        @(negedge clk_50MHz);
        bus_b.pix_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [8:0] w, input logic last);
        int n;
        bus_b.cmd_word = w;
        bus_b.cmd_last = last;
        bus_b.cmd_req  = 1'b1;
        n = 0;
        #1;
        while (!bus_b.cmd_ack && n < LIMIT) begin
            @(negedge clk_50MHz);
            #1;
            n++;
        end
        check("cmd_ack_timeout", {31'd0, n >= LIMIT}, 32'd0);
        @(negedge clk_50MHz);
        bus_b.cmd_req = 1'b0;
    endtask

    task automatic init_word(input logic [8:0] w);
        int n;
        @(negedge clk_50MHz);
        bus_b.init_data = w;
        bus_b.init_en   = 1'b1;
        push_b(w);
        #1;
        check("init_mirror_en", {31'd0, bus_b.lcd_en}, 32'd1);
        check("init_mirror_data", {23'd0, bus_b.lcd_data}, {23'd0, w});
        n = 0;
        do begin
            @(posedge clk_50MHz);
            n++;
        end while (!bus_b.wr_done && n < LIMIT);
        check("init_wr_done_timeout", {31'd0, n >= LIMIT}, 32'd0);
        @(negedge clk_50MHz);
        bus_b.init_en = 1'b0;
        #1;
        check("init_mirror_en_low", {31'd0, bus_b.lcd_en}, 32'd0);
    endtask

    task automatic wait_b(input int target_fd, input bit need_idle);
        int n;
        n = 0;
        while ((fd_cnt_b < target_fd || exp_b.size() != 0 || (need_idle && bus_b.busy)) && n < LIMIT * 4) begin
            @(negedge clk_50MHz);
            #1;
            n++;
        end
        check("drain_timeout", {31'd0, n >= LIMIT * 4}, 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin : main
        int viol;
        rst_b = 1'b1;
        bus_b.init_done = 1'b0;
        bus_b.init_data = 9'h000;
        bus_b.init_en   = 1'b0;
        bus_b.frame_en  = 1'b0;
        bus_b.pix_data  = 16'h0000;
        bus_b.pix_valid = 1'b0;
        bus_b.cmd_req   = 1'b0;
        bus_b.cmd_word  = 9'h000;
        bus_b.cmd_last  = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        #1;
        check("rst_busy", {31'd0, bus_b.busy}, 32'd1);
        check("rst_pix_ready", {31'd0, bus_b.pix_ready}, 32'd0);
        check("rst_cmd_ack", {31'd0, bus_b.cmd_ack}, 32'd0);
        check("rst_frame_start", {31'd0, bus_b.frame_start}, 32'd0);
        check("rst_frame_done", {31'd0, bus_b.frame_done}, 32'd0);
        rst_b = 1'b0;

        // Init pass-through.
        init_word(9'h011);
        init_word(9'h129);
        @(negedge clk_50MHz);
        bus_b.init_done = 1'b1;
        #1;
        check("init_busy_before", {31'd0, bus_b.busy}, 32'd1);
        @(negedge clk_50MHz);
        #1;
        check("init_busy_after", {31'd0, bus_b.busy}, 32'd0);

        // Idle with frames disabled: port stays quiet.
        viol = 0;
        repeat (100) begin
            @(negedge clk_50MHz);
            #1;
            if (bus_b.lcd_en || bus_b.busy) viol++;
        end
        check("idle_quiet_cycles", viol, 32'd0);

        // Aux burst served from IDLE without frames.
        push_b(9'h0B1);
        push_b(9'h1AA);
        @(negedge clk_50MHz);
        send_cmd(9'h0B1, 1'b0);
        send_cmd(9'h1AA, 1'b1);
        wait_b(0, 1'b1);
        check("idle_burst_acks", ack_b, 32'd2);

        // Frame 1, aux burst queued mid-frame, frame 2, start of frame 3.
        push_win_2x2();
        push_b(9'h1F8); push_b(9'h100); push_b(9'h107); push_b(9'h1E0);
        push_b(9'h100); push_b(9'h11F); push_b(9'h1FF); push_b(9'h1FF);
        push_b(9'h036); push_b(9'h160);
        push_win_2x2();
        push_b(9'h113); push_b(9'h157); push_b(9'h124); push_b(9'h168);
        push_b(9'h1AB); push_b(9'h1CD); push_b(9'h100); push_b(9'h101);
        push_win_2x2();
        @(negedge clk_50MHz);
        bus_b.frame_en = 1'b1;
        fork
            begin
                drive_pixel(16'hF800, 3);
                drive_pixel(16'h07E0, 0);
                drive_pixel(16'h001F, 5);
                drive_pixel(16'hFFFF, 1);
                drive_pixel(16'h1357, 0);
                drive_pixel(16'h2468, 2);
                drive_pixel(16'hABCD, 4);
                drive_pixel(16'h0001, 0);
                drive_pixel(16'h1234, 0);
            end
            begin
                repeat (20) @(negedge clk_50MHz);
                send_cmd(9'h036, 1'b0);
                send_cmd(9'h160, 1'b1);
            end
        join
        #1;
        check("pixhi_lcd_en", {31'd0, bus_b.lcd_en}, 32'd1);
        check("pixhi_lcd_data", {23'd0, bus_b.lcd_data}, {23'd0, 9'h112});
        check("frames_done_before_rst", fd_cnt_b, 32'd2);
        check("acks_before_rst", ack_b, 32'd4);
        check("queue_before_rst", exp_b.size(), 32'd0);

        // Reset while a pixel byte is on the port.
        rst_b = 1'b1;
        bus_b.init_done = 1'b0;
        bus_b.init_en   = 1'b0;
        @(negedge clk_50MHz);
        rst_b = 1'b0;
        #1;
        check("postrst_lcd_en", {31'd0, bus_b.lcd_en}, 32'd0);
        check("postrst_busy", {31'd0, bus_b.busy}, 32'd1);
        check("postrst_pix_ready", {31'd0, bus_b.pix_ready}, 32'd0);
        check("postrst_frame_done", {31'd0, bus_b.frame_done}, 32'd0);

        // Frame 4 restarts from the window and a zero pixel count; frame_en drops mid-frame.
        push_win_2x2();
        push_b(9'h1F8); push_b(9'h100); push_b(9'h107); push_b(9'h1E0);
        push_b(9'h100); push_b(9'h11F); push_b(9'h1FF); push_b(9'h1FF);
        @(negedge clk_50MHz);
        bus_b.init_done = 1'b1;
        drive_pixel(16'hF800, 1);
        drive_pixel(16'h07E0, 1);
        drive_pixel(16'h001F, 0);
        drive_pixel(16'hFFFF, 2);
        bus_b.frame_en = 1'b0;
        wait_b(3, 1'b1);
        repeat (5) @(negedge clk_50MHz);
        #1;
        check("end_busy", {31'd0, bus_b.busy}, 32'd0);
        check("end_lcd_en", {31'd0, bus_b.lcd_en}, 32'd0);
        check("end_frame_starts", fs_cnt_b, 32'd4);
        check("end_frame_dones", fd_cnt_b, 32'd3);
        check("end_pix_transfers", xfer_b, 32'd13);
        check("end_cmd_acks", ack_b, 32'd4);
        check("end_queue_b", exp_b.size(), 32'd0);
        check("a_queue_empty", exp_a.size(), 32'd0);
        check("a_frame_starts", fs_cnt_a, 32'd1);
        check("a_waits_in_fetch", {31'd0, bus_a.pix_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
